snoop_bus_arbiter: RTL

SNOOP_BUS_ARBITER -- requirements
Module: snoop_bus_arbiter

---
 rtl/snoop_bus_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/snoop_bus_arbiter.sv
//------------------------------------------------------------------------------
// Module      : snoop_bus_arbiter
// Description : Two-core snoop bus arbiter with per-core command FIFOs and
//               round-robin arbitration onto a shared registered broadcast bus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module snoop_bus_arbiter #(
    parameter int ADDR_BITS  = 11,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [1:0]           c0_cmd,
    input  logic [ADDR_BITS-1:0] c0_addr,
    input  logic [DATA_BITS-1:0] c0_data,
    input  logic [1:0]           c1_cmd,
    input  logic [ADDR_BITS-1:0] c1_addr,
    input  logic [DATA_BITS-1:0] c1_data,
    output logic [1:0]           bus_cmd_out,
    output logic [ADDR_BITS-1:0] bus_addr_out,
    output logic [DATA_BITS-1:0] bus_data_out,
    output logic                 bus_src_out,
    output logic                 c0_ovf,
    output logic                 c1_ovf,
    output logic                 busy
);

    localparam int ENTRY_W = 2 + ADDR_BITS + DATA_BITS;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);

    logic [1:0][ENTRY_W-1:0] w_in_entry;
    logic [1:0][ENTRY_W-1:0] w_head;
    logic [1:0]              w_push;
    logic [1:0]              w_accept;
    logic [1:0]              w_pop;
    logic [1:0]              w_nonempty;
    logic [1:0]              w_ovf;
    logic                    w_gnt;
    logic                    r_last_grant;

    assign w_in_entry[0] = {c0_cmd, c0_addr, c0_data};
    assign w_in_entry[1] = {c1_cmd, c1_addr, c1_data};

    generate
        for (genvar g = 0; g < 2; g++) begin : g_fifo
            logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
            logic [PTR_W-1:0]   r_wptr;
            logic [PTR_W-1:0]   r_rptr;
            logic [CNT_W-1:0]   r_count;
            logic               r_ovf;
            logic               w_full;

            assign w_push[g]     = (w_in_entry[g][ENTRY_W-1 -: 2] != 2'b00);
            assign w_nonempty[g] = (r_count != '0);
            assign w_full        = (r_count == CNT_W'(FIFO_DEPTH));
            // A full FIFO still accepts a push when its head leaves at the same edge.
            assign w_accept[g]   = w_push[g] & (~w_full | w_pop[g]);
            assign w_head[g]     = r_mem[r_rptr];
            assign w_ovf[g]      = r_ovf;

            always_ff @(posedge clk) begin
                if (w_accept[g]) begin
                    r_mem[r_wptr] <= w_in_entry[g];
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                    r_ovf   <= 1'b0;
                end else begin
                    if (w_accept[g]) begin
                        r_wptr <= r_wptr + PTR_W'(1);
                    end
                    if (w_pop[g]) begin
                        r_rptr <= r_rptr + PTR_W'(1);
                    end
                    r_count <= r_count + CNT_W'(w_accept[g]) - CNT_W'(w_pop[g]);
                    if (w_push[g] && !w_accept[g]) begin
                        r_ovf <= 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Occupancy before this edge's push decides the grant; contention alternates.
    assign w_gnt    = (&w_nonempty) ? ~r_last_grant : w_nonempty[1];
    assign w_pop[0] = w_nonempty[0] & ~w_gnt;
    assign w_pop[1] = w_nonempty[1] & w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_cmd_out  <= 2'b00;
            bus_addr_out <= '0;
            bus_data_out <= '0;
            bus_src_out  <= 1'b0;
            r_last_grant <= 1'b1;
        end else if (|w_nonempty) begin
            {bus_cmd_out, bus_addr_out, bus_data_out} <= w_head[w_gnt];
            bus_src_out  <= w_gnt;
            r_last_grant <= w_gnt;
        end else begin
            bus_cmd_out  <= 2'b00;
            bus_addr_out <= '0;
            bus_data_out <= '0;
            bus_src_out  <= 1'b0;
        end
    end

    assign c0_ovf = w_ovf[0];
    assign c1_ovf = w_ovf[1];
    assign busy   = |w_nonempty;

endmodule

`default_nettype wire
